// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory-map arbiter.
// Holds the FSM state type and the master index constants.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_fsm_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// Combinational winner selection between two requesters.
// Under contention it picks round-robin against last_gnt, or always M0 when RR_EN is 0.
module mem_bus_arbiter_rr_priority_picker
   import mem_bus_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic [1:0] req_i,
   input  logic       last_gnt_i,
   output logic       gnt_idx_o,
   output logic       any_req_o
);

   always_comb begin
      any_req_o = |req_i;
      gnt_idx_o = M0;
      case (req_i)
         2'b01:   gnt_idx_o = M0;
         2'b10:   gnt_idx_o = M1;
         2'b11:   gnt_idx_o = RR_EN ? ~last_gnt_i : M0;
         default: gnt_idx_o = M0;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory-map port between two masters: IDLE -> ACCESS (one mm cycle) -> RESP (ack).
// All outputs are registered; every transaction takes exactly three cycles.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter bit          RR_EN      = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  m0_req_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_wdata_i,
   output logic                  m0_ack_o,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_wdata_i,
   output logic                  m1_ack_o,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic                  mm_re_o,
   output logic                  mm_we_o,
   output logic [ADDR_WIDTH-1:0] mm_addr_o,
   output logic [DATA_WIDTH-1:0] mm_wdata_o,
   input  logic [DATA_WIDTH-1:0] mm_rdata_i,
   output logic                  arb_owner_o,
   output arb_fsm_state_t        arb_state_o
);

   arb_fsm_state_t        state_q;
   logic                  owner_q, we_q, last_gnt_q;
   logic                  mm_re_q, mm_we_q, m0_ack_q, m1_ack_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q, m0_rdata_q, m1_rdata_q;

   logic                  gnt_idx, any_req;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata, resp_rdata;

   mem_bus_arbiter_rr_priority_picker #(
      .RR_EN (RR_EN)
   ) u_picker (
      .req_i      ({m1_req_i, m0_req_i}),
      .last_gnt_i (last_gnt_q),
      .gnt_idx_o  (gnt_idx),
      .any_req_o  (any_req)
   );

   always_comb begin
      sel_we    = m0_we_i;
      sel_addr  = m0_addr_i;
      sel_wdata = m0_wdata_i;
      if (gnt_idx == M1) begin
         sel_we    = m1_we_i;
         sel_addr  = m1_addr_i;
         sel_wdata = m1_wdata_i;
      end
   end

   // A write returns the previously captured read data unchanged.
   assign resp_rdata = we_q ? rdata_q : mm_rdata_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         owner_q    <= M0;
         we_q       <= 1'b0;
         last_gnt_q <= M1;
         mm_re_q    <= 1'b0;
         mm_we_q    <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         mm_re_q  <= 1'b0;
         mm_we_q  <= 1'b0;
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         unique case (state_q)
            ARB_IDLE: begin
               if (any_req) begin
                  owner_q <= gnt_idx;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  mm_re_q <= ~sel_we;
                  mm_we_q <= sel_we;
                  state_q <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               if (!we_q) rdata_q <= mm_rdata_i;
               if (owner_q == M1) begin
                  m1_ack_q   <= 1'b1;
                  m1_rdata_q <= resp_rdata;
               end else begin
                  m0_ack_q   <= 1'b1;
                  m0_rdata_q <= resp_rdata;
               end
               state_q <= ARB_RESP;
            end
            ARB_RESP: begin
               last_gnt_q <= owner_q;
               state_q    <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign m0_ack_o    = m0_ack_q;
   assign m1_ack_o    = m1_ack_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
   assign mm_re_o     = mm_re_q;
   assign mm_we_o     = mm_we_q;
   assign mm_addr_o   = addr_q;
   assign mm_wdata_o  = wdata_q;
   assign arb_owner_o = owner_q;
   assign arb_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter against a transaction-level timing model.
// A second, fixed-priority instance is checked for M1 starvation under constant contention.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [1:0]     req, we;
   logic [31:0]    addr [2];
   logic [31:0]    wdata [2];
   logic           ack0, ack1, mm_re, mm_we, owner;
   logic [31:0]    rdata0, rdata1, mm_addr, mm_wdata, mm_rdata;
   arb_fsm_state_t state;

   logic           f_rst_n;
   logic           f_ack0, f_ack1, f_re, f_we, f_owner;
   logic [31:0]    f_rdata0, f_rdata1, f_addr, f_wdata;
   arb_fsm_state_t f_state;

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h1000_0004) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   assign mm_rdata = mem_fn(mm_addr);

   mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RR_EN(1'b1)) u_dut (
      .clk_i (clk), .rst_ni (rst_n),
      .m0_req_i (req[0]), .m0_we_i (we[0]), .m0_addr_i (addr[0]), .m0_wdata_i (wdata[0]),
      .m0_ack_o (ack0), .m0_rdata_o (rdata0),
      .m1_req_i (req[1]), .m1_we_i (we[1]), .m1_addr_i (addr[1]), .m1_wdata_i (wdata[1]),
      .m1_ack_o (ack1), .m1_rdata_o (rdata1),
      .mm_re_o (mm_re), .mm_we_o (mm_we), .mm_addr_o (mm_addr), .mm_wdata_o (mm_wdata),
      .mm_rdata_i (mm_rdata), .arb_owner_o (owner), .arb_state_o (state)
   );

   mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RR_EN(1'b0)) u_fix (
      .clk_i (clk), .rst_ni (f_rst_n),
      .m0_req_i (1'b1), .m0_we_i (1'b0), .m0_addr_i (32'h10), .m0_wdata_i (32'h0),
      .m0_ack_o (f_ack0), .m0_rdata_o (f_rdata0),
      .m1_req_i (1'b1), .m1_we_i (1'b0), .m1_addr_i (32'h20), .m1_wdata_i (32'h0),
      .m1_ack_o (f_ack1), .m1_rdata_o (f_rdata1),
      .mm_re_o (f_re), .mm_we_o (f_we), .mm_addr_o (f_addr), .mm_wdata_o (f_wdata),
      .mm_rdata_i (32'h1234_5678), .arb_owner_o (f_owner), .arb_state_o (f_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction model: a request sampled at edge S is on the mm port during the cycle after S,
   // acked during the cycle after S+1, and the next request can be sampled at edge S+3.
   int          cyc = 0;
   int          free_from = 0;
   int          t_start = -10;
   bit          txn_v = 1'b0, t_m = 1'b0, t_we = 1'b0, last_gnt = 1'b1, own = 1'b0;
   logic [31:0] t_addr = '0, t_wdata = '0, rdq = '0;
   logic [31:0] exp_rd [2];

   task automatic model_edge();
      cyc++;
      if (!rst_n) begin
         txn_v = 1'b0; free_from = cyc + 1; last_gnt = 1'b1; own = 1'b0;
         rdq = '0; exp_rd[0] = '0; exp_rd[1] = '0;
         return;
      end
      if (txn_v && cyc == t_start + 1) begin
         if (!t_we) rdq = mem_fn(t_addr);
         exp_rd[t_m] = rdq;
      end
      if (txn_v && cyc == t_start + 2) begin
         last_gnt = t_m;
         txn_v    = 1'b0;
      end
      if (cyc >= free_from && req != 2'b00) begin
         t_m     = (req == 2'b11) ? ~last_gnt : req[1];
         txn_v   = 1'b1;
         t_start = cyc;
         t_we    = we[t_m];
         t_addr  = addr[t_m];
         t_wdata = wdata[t_m];
         own     = t_m;
         free_from = cyc + 3;
      end
   endtask

   task automatic check_cycle();
      bit acc, ack;
      arb_fsm_state_t es;
      acc = txn_v && cyc == t_start;
      ack = txn_v && cyc == t_start + 1;
      es  = ARB_IDLE;
      if (acc) es = ARB_ACCESS;
      else if (ack) es = ARB_RESP;
      check_eq("m0_ack", 32'(ack0), 32'(ack && !t_m));
      check_eq("m1_ack", 32'(ack1), 32'(ack && t_m));
      check_eq("mm_re", 32'(mm_re), 32'(acc && !t_we));
      check_eq("mm_we", 32'(mm_we), 32'(acc && t_we));
      check_eq("m0_rdata", rdata0, exp_rd[0]);
      check_eq("m1_rdata", rdata1, exp_rd[1]);
      check_eq("owner", 32'(owner), 32'(own));
      check_eq("state", 32'(state), 32'(es));
      if (acc) begin
         check_eq("mm_addr", mm_addr, t_addr);
         check_eq("mm_wdata", mm_wdata, t_wdata);
      end
   endtask

   initial begin
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      forever begin
         @(posedge clk);
         model_edge();
      end
   end

   initial forever begin
      @(negedge clk);
      check_cycle();
   end

   bit pend [2];

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
      pend[m]  = 1'b1;
      req[m]   = 1'b1;
      we[m]    = w;
      addr[m]  = a;
      wdata[m] = d;
   endtask

   // Master behaviour: hold until ack, optionally drop after grant, optionally issue anew.
   task automatic step(input int unsigned pct, input bit drop_en);
      bit acc, ack;
      acc = txn_v && cyc == t_start;
      ack = txn_v && cyc == t_start + 1;
      for (int m = 0; m < 2; m++) begin
         if (pend[m] && ack && t_m == 1'(m)) begin
            pend[m] = 1'b0;
            req[m]  = 1'b0;
         end else if (pend[m] && drop_en && acc && t_m == 1'(m) && $urandom_range(3, 0) == 0) begin
            req[m] = 1'b0;
         end else if (pend[m] && !req[m] && !(txn_v && t_m == 1'(m))) begin
            pend[m] = 1'b0;
         end
         if (!pend[m] && $urandom_range(99, 0) < pct)
            issue(m, 1'($urandom_range(1, 0)), $urandom, $urandom);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (pend[0] || pend[1]); i++) begin
         tick();
         step(0, 1'b0);
      end
      check_eq("drain", 32'({pend[1], pend[0]}), 32'h0);
   endtask

   int f_cnt0 = 0, f_cnt1 = 0, f_re_cnt = 0, f_we_cnt = 0;
   bit f_done = 1'b0;

   initial begin
      f_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 f_rst_n = 1'b1;
      repeat (90) begin
         @(negedge clk);
         if (f_ack0) f_cnt0++;
         if (f_ack1) f_cnt1++;
         if (f_re) f_re_cnt++;
         if (f_we) f_we_cnt++;
      end
      f_done = 1'b1;
   end

   initial begin
      bit found, seen;
      int prev, nacks, n_ack0, n_re;
      rst_n = 1'b0; req = '0; we = '0;
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;

      // Reset held with a pending M0 read, then the 3-cycle handshake.
      issue(0, 1'b0, 32'h0000_0100, 32'h0);
      tick(); tick();
      check_eq("rst_state", 32'(state), 32'(ARB_IDLE));
      check_eq("rst_ack0", 32'(ack0), 32'h0);
      rst_n = 1'b1;
      tick();
      check_eq("t1_access", 32'(state), 32'(ARB_ACCESS));
      step(0, 1'b0);
      tick();
      check_eq("t1_ack", 32'(ack0), 32'h1);
      step(0, 1'b0);
      drain();

      issue(0, 1'b0, 32'h1000_0004, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (mm_re) check_eq("t2_mm_addr", mm_addr, 32'h1000_0004);
         if (ack0) begin
            seen = 1'b1;
            check_eq("t2_rdata", rdata0, 32'hDEAD_BEEF);
         end
         step(0, 1'b0);
      end
      check_eq("t2_acked", 32'(seen), 32'h1);
      drain();

      issue(1, 1'b1, 32'h1001_0024, 32'h0000_00A5);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (mm_we) begin
            check_eq("t3_mm_addr", mm_addr, 32'h1001_0024);
            check_eq("t3_mm_wdata", mm_wdata, 32'h0000_00A5);
         end
         if (ack1) seen = 1'b1;
         step(0, 1'b0);
      end
      check_eq("t3_acked", 32'(seen), 32'h1);
      drain();

      // Both masters requesting continuously: grants must alternate.
      prev = -1;
      nacks = 0;
      step(100, 1'b0);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ack0 || ack1) begin
            if (prev >= 0) check_eq("t4_alternate", 32'(ack1), 32'(prev == 0));
            prev = ack1 ? 1 : 0;
            nacks++;
         end
         step(100, 1'b0);
      end
      check_eq("t4_ack_count", 32'(nacks >= 12), 32'h1);
      drain();

      // Reset during an M1 access aborts it; afterwards M0 wins contention.
      issue(1, 1'b0, 32'h0000_0040, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick();
         if (state == ARB_ACCESS && owner == M1) found = 1'b1;
         else step(0, 1'b0);
      end
      check_eq("t5_m1_access", 32'(found), 32'h1);
      rst_n = 1'b0;
      issue(0, 1'b0, 32'h0000_0080, 32'h0);
      tick();
      check_eq("t5_idle", 32'(state), 32'(ARB_IDLE));
      check_eq("t5_no_ack1", 32'(ack1), 32'h0);
      rst_n = 1'b1;
      tick();
      check_eq("t5_m0_wins", 32'(owner), 32'h0);
      step(0, 1'b0);
      drain();

      // M0 drops req during its access: exactly one ack, no re-issue.
      issue(0, 1'b0, 32'h0000_0200, 32'h0);
      n_ack0 = 0;
      n_re = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack0) n_ack0++;
         if (mm_re) n_re++;
         if (state == ARB_ACCESS) req[0] = 1'b0;
         step(0, 1'b0);
      end
      check_eq("t6_one_ack", 32'(n_ack0), 32'h1);
      check_eq("t6_one_access", 32'(n_re), 32'h1);
      drain();

      for (int i = 0; i < 400; i++) begin
         tick();
         rst_n = ($urandom_range(39, 0) != 0);
         step(50, 1'b1);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 200 && !f_done; i++) tick();
      check_eq("fix_done", 32'(f_done), 32'h1);
      check_eq("fix_m0_acks", 32'(f_cnt0), 32'd30);
      check_eq("fix_m1_acks", 32'(f_cnt1), 32'd0);
      check_eq("fix_reads", 32'(f_re_cnt), 32'd30);
      check_eq("fix_writes", 32'(f_we_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
